regfile_write_port: RTL and testbench
=====================================

# regfile_write_port

Write-back side of the 32 x 64 register file: accepts register write requests over a valid/ready handshake and buffers them in a small in-order queue. It issues one write per cycle as a one-hot 32-bit enable plus 64-bit data to the register array. It also exposes a bypass lookup, so the read-side 32:1 multiplexer path can forward data that has been accepted but not yet written. X31 is the hardwired zero register; writes to it are consumed and never reach the array.

## Interface
- DATA_W, 64, width of write data and bypass data
- ADDR_W, 5, register address width (NREGS = 2**ADDR_W = 32)
- DEPTH, 2, queue entries (power of two, >= 2)
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the rising edge where it is sampled high
- wr_valid  input  1  write request present
- wr_ready  output  1  block can accept a request this cycle
- wr_addr  input  ADDR_W  destination register
- wr_data  input  DATA_W  value to write
- hold  input  1  register array cannot accept a write this cycle
- wr_en  output  2**ADDR_W  one-hot write enable to the array (all-zero when no write)
- wdata  output  DATA_W  data accompanying wr_en
- busy  output  1  queue non-empty
- chk_addr  input  ADDR_W  address being read by the read path
- chk_hit  output  1  a queued entry targets chk_addr
- chk_data  output  DATA_W  data of the youngest matching queued entry

## Operation
- Queue: circular buffer with DEPTH entries, each holding {addr, data}, plus head pointer, tail pointer, and count (0..DEPTH). Pointers wrap modulo DEPTH.
- Push: wr_valid && wr_ready at an edge writes {wr_addr, wr_data} at tail; tail++, count++.
- wr_ready = (count < DEPTH). There is no same-cycle pass-through when full.
- Issue: when count > 0 and hold == 0, wr_en = decode(head.addr) and wdata = head.data.
  - At the next edge, pop: head++, count--.
  - If head.addr == 31, wr_en = 0 but the entry is still popped.
- Output defaults:
  - wr_en = 0 when count == 0 or hold == 1.
  - wdata = head.data when count > 0, else 0.
- Push and pop may occur on the same edge; count is unchanged in that case.
- hold == 1 freezes the head. Pushes continue until the queue is full.
- Bypass (combinational): compare chk_addr against every valid entry.
  - chk_hit = 1 if any entry matches and chk_addr != 31.
  - chk_data = data of the youngest matching entry (closest to tail); chk_data = 0 when chk_hit = 0.
  - The head entry being written this cycle still counts as a hit.
  - The incoming wr_data is not checked.
- Reset values: count = 0, head = tail = 0, wr_ready = 1, busy = 0, wr_en = 0, wdata = 0, chk_hit = 0, chk_data = 0. Stored data need not be cleared.

## Timing
- Latency: a request accepted at edge E drives wr_en/wdata in the cycle after E if the queue was empty and hold == 0. It pops at edge E+1.
- Throughput: one write per cycle while hold == 0. The queue never fills under continuous push with no hold.
- Full: count == DEPTH gives wr_ready = 0. The producer must hold wr_valid, wr_addr and wr_data stable until accepted.
- Simultaneous push while full: no push, because wr_ready = 0, even if a pop happens on the same edge. wr_ready rises the cycle after the pop.
- Reset mid-operation: all queued writes are discarded. wr_en = 0 in the cycle after the reset edge, and nothing is written afterwards.
- wr_en, wdata, wr_ready and busy are functions of registered state and hold only. chk_hit and chk_data are combinational from chk_addr and registered state.

## Test plan
- Reset then a single push {addr 5, data 0xDEAD_BEEF_0000_0001} with hold = 0:
  - next cycle wr_en = 0x0000_0020 and wdata matches;
  - following cycle wr_en = 0 and busy = 0.
- Back-to-back pushes to addrs 0, 1, 2 over 3 cycles with hold = 0: wr_en = 0x1, 0x2, 0x4 on consecutive cycles; wr_ready stays 1 throughout.
- hold = 1 while pushing addrs 3 and 4:
  - after 2 accepts, wr_ready = 0 and wr_en = 0;
  - release hold: wr_en = 0x8 then 0x10; wr_ready returns to 1 the cycle after the first pop.
- Bypass with hold = 1, push addr 7 data 0xA, then addr 7 data 0xB:
  - chk_addr = 7 gives chk_hit = 1, chk_data = 0xB;
  - chk_addr = 6 gives chk_hit = 0, chk_data = 0.
- Push addr 31 data 0xFFFF: busy = 1 for one cycle, wr_en stays 0, and chk_addr = 31 gives chk_hit = 0.
- With 2 entries queued under hold, assert reset for one edge: wr_en = 0, busy = 0, wr_ready = 1 afterwards; releasing hold produces no writes.

Source files
------------

// File: rtl/regfile_write_port_if.sv
// Write-request handshake into the register-file write port.
// Producer holds valid/addr/data stable until ready is seen.
interface regfile_write_port_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_addr,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_addr,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/regfile_write_port.sv
// Write-back queue for the 32x64 register file.
// Issues one-hot writes in order and forwards queued data to the read path.
module regfile_write_port #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_write_port_if.slave    wr,
    input  logic                   hold,
    output logic [2**ADDR_W-1:0]   wr_en,
    output logic [DATA_W-1:0]      wdata,
    output logic                   busy,
    input  logic [ADDR_W-1:0]      chk_addr,
    output logic                   chk_hit,
    output logic [DATA_W-1:0]      chk_data
);
    localparam int NREGS = 2**ADDR_W;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] ZERO_REG = '1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push;
    logic pop;
    logic nonempty;

    assign nonempty    = (count_q != '0);
    assign wr.wr_ready = (count_q < CNT_W'(DEPTH));
    assign push        = wr.wr_valid && wr.wr_ready;
    assign pop         = nonempty && !hold;
    assign busy        = nonempty;

    always_comb begin
        wr_en = '0;
        wdata = '0;
        if (nonempty) begin
            wdata = data_q[head_q];
        end
        if (pop && addr_q[head_q] != ZERO_REG) begin
            wr_en = NREGS'(1) << addr_q[head_q];
        end
    end

    always_comb begin
        head_d  = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        chk_hit  = 1'b0;
        chk_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && addr_q[idx] == chk_addr) begin
                chk_hit  = 1'b1;
                chk_data = data_q[idx];
            end
        end
        if (chk_addr == ZERO_REG) begin
            chk_hit  = 1'b0;
            chk_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            addr_q[tail_q] <= wr.wr_addr;
            data_q[tail_q] <= wr.wr_data;
        end
    end
endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: issue order, hold,
// bypass lookup, zero register and mid-operation reset.
module tb_regfile_write_port;
    logic        clk;
    logic        reset;
    logic        hold;
    logic [31:0] wr_en;
    logic [63:0] wdata;
    logic        busy;
    logic [4:0]  chk_addr;
    logic        chk_hit;
    logic [63:0] chk_data;

    int checks;
    int failures;

    regfile_write_port_if #(.ADDR_W(5), .DATA_W(64)) wif ();

    regfile_write_port #(.DATA_W(64), .ADDR_W(5), .DEPTH(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wif.slave),
        .hold     (hold),
        .wr_en    (wr_en),
        .wdata    (wdata),
        .busy     (busy),
        .chk_addr (chk_addr),
        .chk_hit  (chk_hit),
        .chk_data (chk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [63:0] d);
        wif.wr_valid = 1'b1;
        wif.wr_addr  = a;
        wif.wr_data  = d;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b1;
        hold         = 1'b0;
        chk_addr     = 5'd0;
        wif.wr_valid = 1'b0;
        wif.wr_addr  = '0;
        wif.wr_data  = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_ready", 64'(wif.wr_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_wdata", wdata, 64'd0);
        check("rst_hit", 64'(chk_hit), 64'd0);
        check("rst_cdata", chk_data, 64'd0);

        // single push
        push(5'd5, 64'hDEAD_BEEF_0000_0001);
        step();
        wif.wr_valid = 1'b0;
        check("t1_wr_en", 64'(wr_en), 64'h20);
        check("t1_wdata", wdata, 64'hDEAD_BEEF_0000_0001);
        check("t1_busy", 64'(busy), 64'd1);
        step();
        check("t1_wr_en_after", 64'(wr_en), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);

        // back-to-back
        push(5'd0, 64'h100);
        step();
        push(5'd1, 64'h101);
        check("t2_en0", 64'(wr_en), 64'h1);
        check("t2_rdy0", 64'(wif.wr_ready), 64'd1);
        step();
        push(5'd2, 64'h102);
        check("t2_en1", 64'(wr_en), 64'h2);
        check("t2_d1", wdata, 64'h101);
        check("t2_rdy1", 64'(wif.wr_ready), 64'd1);
        step();
        wif.wr_valid = 1'b0;
        check("t2_en2", 64'(wr_en), 64'h4);
        check("t2_rdy2", 64'(wif.wr_ready), 64'd1);
        step();
        check("t2_idle", 64'(busy), 64'd0);

        // hold fills the queue
        hold = 1'b1;
        push(5'd3, 64'h3);
        step();
        check("t3_rdy_1", 64'(wif.wr_ready), 64'd1);
        check("t3_en_1", 64'(wr_en), 64'd0);
        push(5'd4, 64'h4);
        step();
        wif.wr_valid = 1'b0;
        check("t3_rdy_full", 64'(wif.wr_ready), 64'd0);
        check("t3_en_held", 64'(wr_en), 64'd0);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_wdata_held", wdata, 64'h3);
        hold = 1'b0;
        #1;
        check("t3_en_a", 64'(wr_en), 64'h8);
        check("t3_rdy_pop", 64'(wif.wr_ready), 64'd0);
        step();
        check("t3_en_b", 64'(wr_en), 64'h10);
        check("t3_rdy_back", 64'(wif.wr_ready), 64'd1);
        step();
        check("t3_idle", 64'(busy), 64'd0);

        // bypass, youngest wins
        hold = 1'b1;
        push(5'd7, 64'hA);
        step();
        push(5'd7, 64'hB);
        step();
        wif.wr_valid = 1'b0;
        chk_addr = 5'd7;
        #1;
        check("t4_hit7", 64'(chk_hit), 64'd1);
        check("t4_data7", chk_data, 64'hB);
        chk_addr = 5'd6;
        #1;
        check("t4_hit6", 64'(chk_hit), 64'd0);
        check("t4_data6", chk_data, 64'd0);
        hold = 1'b0;
        chk_addr = 5'd7;
        #1;
        check("t4_en_a", 64'(wr_en), 64'h80);
        check("t4_wd_a", wdata, 64'hA);
        check("t4_hit_issue", 64'(chk_hit), 64'd1);
        step();
        check("t4_en_b", 64'(wr_en), 64'h80);
        check("t4_wd_b", wdata, 64'hB);
        check("t4_data_last", chk_data, 64'hB);
        step();
        check("t4_idle", 64'(busy), 64'd0);
        check("t4_hit_gone", 64'(chk_hit), 64'd0);

        // zero register
        push(5'd31, 64'hFFFF);
        step();
        wif.wr_valid = 1'b0;
        chk_addr = 5'd31;
        #1;
        check("t5_busy", 64'(busy), 64'd1);
        check("t5_en", 64'(wr_en), 64'd0);
        check("t5_hit31", 64'(chk_hit), 64'd0);
        step();
        check("t5_idle", 64'(busy), 64'd0);
        check("t5_en_after", 64'(wr_en), 64'd0);

        // reset discards queued writes
        hold = 1'b1;
        push(5'd9, 64'h9);
        step();
        push(5'd10, 64'h10);
        step();
        wif.wr_valid = 1'b0;
        chk_addr = 5'd9;
        #1;
        check("t6_busy_pre", 64'(busy), 64'd1);
        check("t6_hit_pre", 64'(chk_hit), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("t6_en", 64'(wr_en), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_rdy", 64'(wif.wr_ready), 64'd1);
        check("t6_hit", 64'(chk_hit), 64'd0);
        hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t6_no_write", 64'(wr_en), 64'd0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
